kyo_jump_sprite_fetch: RTL and testbench
========================================

KYO_JUMP_SPRITE_FETCH -- requirements
Module: kyo_jump_sprite_fetch

Interface
REQ-001 SHALL have parameter SPR_W, default 64: sprite width in pixels.
REQ-002 SHALL have parameter SPR_H, default 96: sprite height in pixels.
REQ-003 SHALL have parameter FRAMES, default 6: number of jump animation frames in the ROM.
REQ-004 SHALL have parameter HOLD, default 4: video frames each animation frame is displayed.
REQ-005 SHALL have parameter ADDR_W, default 16: ROM address width, which must be at least clog2(SPR_W*SPR_H*FRAMES).
REQ-006 SHALL have the port Clk  in  1  system clock, with all logic on its rising edge.
REQ-007 SHALL have the port Reset  in  1  reset, which is synchronous and active-high.
REQ-008 SHALL have the port frame_clk  in  1  vertical-sync level, already in the Clk domain.
REQ-009 SHALL have the port start  in  1  single-cycle jump trigger.
REQ-010 SHALL have the port facing_left  in  1  horizontal mirror select.
REQ-011 SHALL have the ports pos_x, pos_y  in  10 each  sprite top-left corner in screen pixels.
REQ-012 SHALL have the ports DrawX, DrawY  in  10 each  current VGA pixel coordinate.
REQ-013 SHALL have the port rom_addr  out  ADDR_W  address to the sprite ROM.
REQ-014 SHALL have the port rom_data  in  4  ROM read data, valid one Clk after rom_addr.
REQ-015 SHALL have the port index  out  4  palette index fed to the 16-entry palette lookup.
REQ-016 SHALL have the port opaque  out  1  pixel is sprite and not transparent.
REQ-017 SHALL have the port busy  out  1  jump animation in progress.
REQ-018 SHALL have the port frame_num  out  3  current animation frame.

Function
REQ-019 SHALL detect a frame_clk rising edge (fc_edge) by registering frame_clk once and comparing, with no other synchronisation.
REQ-020 SHALL implement FSM states IDLE and PLAY, with busy=1 exactly in PLAY.
REQ-021 SHALL move IDLE->PLAY on start=1, clearing frame_num and hold_cnt to 0, and SHALL NOT count an fc_edge in that same cycle.
REQ-022 SHALL ignore start while in PLAY, with no restart.
REQ-023 SHALL, in PLAY on each fc_edge: if hold_cnt<HOLD-1 increment hold_cnt; else clear hold_cnt and, if frame_num<FRAMES-1, increment frame_num; otherwise go to IDLE with frame_num=0.
REQ-024 SHALL change frame_num only on fc_edge, so the frame never changes mid-scan.
REQ-025 SHALL compute in-box with 11-bit unsigned arithmetic, with no wrap: pos_x<=DrawX<pos_x+SPR_W and pos_y<=DrawY<pos_y+SPR_H; a box extending past 1023 SHALL be clipped, not wrapped.
REQ-026 SHALL compute col=DrawX-pos_x and row=DrawY-pos_y, using col'=SPR_W-1-col when facing_left=1 and col'=col otherwise.
REQ-027 SHALL compute address = frame_num*SPR_W*SPR_H + row*SPR_W + col', truncated to ADDR_W.
REQ-028 SHALL have pipeline stage 1 register rom_addr and in_box_d1; rom_addr SHALL be 0 when out of box.
REQ-029 SHALL have pipeline stage 2 register index=rom_data and opaque=(rom_data!=1) when in_box_d1=1; otherwise index=0 and opaque=0.
REQ-030 SHALL give a total latency of 2 Clk from DrawX/DrawY to index/opaque, with the caller delaying DrawX/DrawY-aligned signals by 2.
REQ-031 SHALL treat index 1 (magenta) as the transparent key, passing it through on index with opaque=0.
REQ-032 SHALL use the frame_num registered at the start of each cycle for address generation, so a same-cycle FSM update affects the next pixel.

Reset
REQ-033 SHALL, on Reset=1 at a Clk edge, set FSM=IDLE, frame_num=0, hold_cnt=0, the frame_clk delay register=0, rom_addr=0, in_box_d1=0, index=0, opaque=0 and busy=0.
REQ-034 SHALL have Reset take priority over start and fc_edge in the same cycle.
REQ-035 SHALL, on Reset mid-PLAY, abort the animation, and the next start SHALL begin from frame 0.

Verification
REQ-036 SHALL cover: pos=(100,200), IDLE, DrawX=100 DrawY=200 -> rom_addr=0 after 1 Clk; index=rom_data[0] and opaque=(rom_data!=1) after 2 Clk.
REQ-037 SHALL cover: facing_left=1, DrawX=100 DrawY=201 -> rom_addr=127 (64+63).
REQ-038 SHALL cover: start, then 24 fc_edges -> frame_num steps 0..5 every 4 edges; busy drops on the 24th edge; frame_num returns to 0.
REQ-039 SHALL cover: start on the same cycle as an fc_edge, then 3 more edges -> frame_num still 0, and the 4th edge after start -> 1.
REQ-040 SHALL cover: pos_x=1000, DrawX=1023 in-box and DrawX=3 -> out-of-box (index=0, opaque=0), with no wrap.
REQ-041 SHALL cover: Reset asserted at frame_num=3 together with start -> all outputs zero next cycle, busy=0, start not taken.

Source files
------------

// File: rtl/kyo_jump_sprite_fetch.sv
// Jump-animation sprite fetcher: IDLE/PLAY frame sequencer paced by vsync edges,
// plus a two-stage pixel pipeline producing ROM address, palette index and opacity.
module kyo_jump_sprite_fetch #(
  parameter int SPR_W  = 64,
  parameter int SPR_H  = 96,
  parameter int FRAMES = 6,
  parameter int HOLD   = 4,
  parameter int ADDR_W = 16
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              frame_clk,
  input  logic              start,
  input  logic              facing_left,
  input  logic [9:0]        pos_x,
  input  logic [9:0]        pos_y,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [3:0]        rom_data,
  output logic [3:0]        index,
  output logic              opaque,
  output logic              busy,
  output logic [2:0]        frame_num
);

  localparam int HC_W = (HOLD > 1) ? $clog2(HOLD) : 1;

  typedef enum logic {IDLE = 1'b0, PLAY = 1'b1} state_t;

  state_t            r_state, w_state_next;
  logic [2:0]        r_frame_num, w_frame_num_next;
  logic [HC_W-1:0]   r_hold_cnt, w_hold_cnt_next;
  logic              r_fc_d;
  logic              w_fc_edge;
  logic [ADDR_W-1:0] r_rom_addr;
  logic              r_in_box_d1;
  logic [3:0]        r_index;
  logic              r_opaque;

  assign w_fc_edge = frame_clk & ~r_fc_d;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state     <= IDLE;
      r_frame_num <= '0;
      r_hold_cnt  <= '0;
      r_fc_d      <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_frame_num <= w_frame_num_next;
      r_hold_cnt  <= w_hold_cnt_next;
      r_fc_d      <= frame_clk;
    end
  end

  // The edge arriving in the same cycle as start is deliberately not counted.
  always_comb begin
    w_state_next     = r_state;
    w_frame_num_next = r_frame_num;
    w_hold_cnt_next  = r_hold_cnt;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_next     = PLAY;
          w_frame_num_next = '0;
          w_hold_cnt_next  = '0;
        end
      end
      PLAY: begin
        if (w_fc_edge) begin
          if (r_hold_cnt < HC_W'(HOLD - 1)) begin
            w_hold_cnt_next = r_hold_cnt + 1'b1;
          end else begin
            w_hold_cnt_next = '0;
            if (r_frame_num < 3'(FRAMES - 1)) begin
              w_frame_num_next = r_frame_num + 3'd1;
            end else begin
              w_state_next     = IDLE;
              w_frame_num_next = '0;
            end
          end
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // 11-bit compare so a box hanging past x/y=1023 clips instead of wrapping.
  logic [10:0]       w_dx, w_dy, w_px, w_py, w_x_end, w_y_end;
  logic              w_in_box;
  logic [9:0]        w_col, w_row, w_col_m;
  logic [ADDR_W-1:0] w_addr;

  assign w_dx     = {1'b0, DrawX};
  assign w_dy     = {1'b0, DrawY};
  assign w_px     = {1'b0, pos_x};
  assign w_py     = {1'b0, pos_y};
  assign w_x_end  = w_px + 11'(SPR_W);
  assign w_y_end  = w_py + 11'(SPR_H);
  assign w_in_box = (w_dx >= w_px) && (w_dx < w_x_end) &&
                    (w_dy >= w_py) && (w_dy < w_y_end);

  assign w_col   = DrawX - pos_x;
  assign w_row   = DrawY - pos_y;
  assign w_col_m = facing_left ? (10'(SPR_W - 1) - w_col) : w_col;
  assign w_addr  = ADDR_W'(r_frame_num) * ADDR_W'(SPR_W * SPR_H) +
                   ADDR_W'(w_row) * ADDR_W'(SPR_W) + ADDR_W'(w_col_m);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_rom_addr  <= '0;
      r_in_box_d1 <= 1'b0;
      r_index     <= '0;
      r_opaque    <= 1'b0;
    end else begin
      r_rom_addr  <= w_in_box ? w_addr : '0;
      r_in_box_d1 <= w_in_box;
      // Index 1 is the transparent key: passed through, but never opaque.
      r_index     <= r_in_box_d1 ? rom_data : 4'd0;
      r_opaque    <= r_in_box_d1 && (rom_data != 4'd1);
    end
  end

  assign rom_addr  = r_rom_addr;
  assign index     = r_index;
  assign opaque    = r_opaque;
  assign busy      = (r_state == PLAY);
  assign frame_num = r_frame_num;

endmodule

// File: tb/tb_kyo_jump_sprite_fetch.sv
// Directed bench for kyo_jump_sprite_fetch: pixel-pipeline vector table plus
// hand-written animation, start/edge collision and reset sequences.
module tb_kyo_jump_sprite_fetch;

  logic        Clk = 1'b0;
  logic        Reset, frame_clk, start, facing_left;
  logic [9:0]  pos_x, pos_y, DrawX, DrawY;
  logic [15:0] rom_addr;
  logic [3:0]  rom_data, index;
  logic        opaque, busy;
  logic [2:0]  frame_num;

  int checks = 0;
  int errors = 0;

  always #5 Clk = ~Clk;

  kyo_jump_sprite_fetch dut (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .start(start),
    .facing_left(facing_left), .pos_x(pos_x), .pos_y(pos_y),
    .DrawX(DrawX), .DrawY(DrawY), .rom_addr(rom_addr), .rom_data(rom_data),
    .index(index), .opaque(opaque), .busy(busy), .frame_num(frame_num)
  );

  typedef struct packed {
    logic [9:0]  px, py, dx, dy;
    logic        fl;
    logic [3:0]  rd;
    logic [15:0] ea;
    logic [3:0]  ei;
    logic        eo;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end else begin
      $display("ok   %s: %0d", name, act);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    @(negedge Clk);
  endtask

  // One frame_clk pulse: rising edge seen at the first posedge, then low again.
  task automatic fc_pulse();
    frame_clk = 1'b1;
    tick();
    frame_clk = 1'b0;
    tick();
  endtask

  task automatic chk_anim(input string name, input logic [2:0] efn, input logic ebusy);
    chk({name, ".frame_num"}, 32'(frame_num), 32'(efn));
    chk({name, ".busy"}, 32'(busy), 32'(ebusy));
  endtask

  initial begin
    vecs[0] = '{px:100,  py:200, dx:100,  dy:200, fl:0, rd:5, ea:0,    ei:5, eo:1};
    vecs[1] = '{px:100,  py:200, dx:100,  dy:201, fl:1, rd:3, ea:127,  ei:3, eo:1};
    vecs[2] = '{px:100,  py:200, dx:163,  dy:295, fl:0, rd:1, ea:6143, ei:1, eo:0};
    vecs[3] = '{px:100,  py:200, dx:164,  dy:200, fl:0, rd:7, ea:0,    ei:0, eo:0};
    vecs[4] = '{px:100,  py:200, dx:99,   dy:200, fl:0, rd:7, ea:0,    ei:0, eo:0};
    vecs[5] = '{px:100,  py:200, dx:100,  dy:296, fl:0, rd:7, ea:0,    ei:0, eo:0};
    vecs[6] = '{px:1000, py:10,  dx:1023, dy:10,  fl:0, rd:9, ea:23,   ei:9, eo:1};
    vecs[7] = '{px:1000, py:10,  dx:3,    dy:10,  fl:0, rd:9, ea:0,    ei:0, eo:0};
    vecs[8] = '{px:1000, py:10,  dx:1023, dy:10,  fl:1, rd:2, ea:40,   ei:2, eo:1};
    vecs[9] = '{px:0,    py:0,   dx:5,    dy:3,   fl:1, rd:0, ea:250,  ei:0, eo:1};

    Reset = 1'b1; frame_clk = 1'b0; start = 1'b0; facing_left = 1'b0;
    pos_x = 10'd100; pos_y = 10'd200; DrawX = 10'd0; DrawY = 10'd0; rom_data = 4'd0;
    @(negedge Clk);
    tick();
    tick();
    chk("reset.rom_addr", 32'(rom_addr), 0);
    chk("reset.index", 32'(index), 0);
    chk("reset.opaque", 32'(opaque), 0);
    chk_anim("reset", 3'd0, 1'b0);
    Reset = 1'b0;
    tick();

    // Pixel pipeline in IDLE (frame 0): address after 1 Clk, index/opaque after 2.
    for (int i = 0; i < 10; i++) begin
      pos_x = vecs[i].px; pos_y = vecs[i].py;
      DrawX = vecs[i].dx; DrawY = vecs[i].dy;
      facing_left = vecs[i].fl;
      rom_data = 4'hF;
      tick();
      chk($sformatf("vec%0d.rom_addr", i), 32'(rom_addr), 32'(vecs[i].ea));
      rom_data = vecs[i].rd;
      tick();
      chk($sformatf("vec%0d.index", i), 32'(index), 32'(vecs[i].ei));
      chk($sformatf("vec%0d.opaque", i), 32'(opaque), 32'(vecs[i].eo));
    end

    // Full animation: 24 edges, frame advances every 4, busy drops on the 24th.
    pos_x = 10'd100; pos_y = 10'd200; DrawX = 10'd100; DrawY = 10'd200;
    facing_left = 1'b0; rom_data = 4'd5;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk_anim("anim.start", 3'd0, 1'b1);
    for (int e = 1; e <= 24; e++) begin
      fc_pulse();
      if (e < 24) chk_anim($sformatf("anim.edge%0d", e), 3'(e / 4), 1'b1);
      else        chk_anim("anim.edge24", 3'd0, 1'b0);
    end

    // start collides with an fc_edge: that edge must not count.
    start = 1'b1; frame_clk = 1'b1;
    tick();
    start = 1'b0; frame_clk = 1'b0;
    tick();
    chk_anim("coll.start", 3'd0, 1'b1);
    for (int e = 1; e <= 3; e++) fc_pulse();
    chk_anim("coll.edge3", 3'd0, 1'b1);
    fc_pulse();
    chk_anim("coll.edge4", 3'd1, 1'b1);
    chk("coll.frame1_addr", 32'(rom_addr), 6144);
    // start during PLAY is ignored.
    start = 1'b1;
    tick();
    start = 1'b0;
    chk_anim("coll.ignore_start", 3'd1, 1'b1);
    for (int e = 1; e <= 8; e++) fc_pulse();
    chk_anim("rst.at_frame3", 3'd3, 1'b1);
    chk("rst.pre_index", 32'(index), 5);
    chk("rst.pre_opaque", 32'(opaque), 1);

    // Reset with start and an fc_edge in the same cycle: reset wins.
    Reset = 1'b1; start = 1'b1; frame_clk = 1'b1;
    tick();
    chk("rst.rom_addr", 32'(rom_addr), 0);
    chk("rst.index", 32'(index), 0);
    chk("rst.opaque", 32'(opaque), 0);
    chk_anim("rst.cycle", 3'd0, 1'b0);
    Reset = 1'b0; start = 1'b0; frame_clk = 1'b0;
    tick();
    chk_anim("rst.no_start", 3'd0, 1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk_anim("rst.restart", 3'd0, 1'b1);
    for (int e = 1; e <= 4; e++) fc_pulse();
    chk_anim("rst.restart_edge4", 3'd1, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
